// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, FSM states and the shared ALU for mips_multicycle_core
package mips_mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  function automatic logic funct_ok(input logic [5:0] f);
    return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
  endfunction
  function automatic alu_op_t funct_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction
  // Operands arrive sign-extended to 64 bits so slt is a correct signed compare at any XLEN
  function automatic logic [63:0] alu(input alu_op_t op, input logic [63:0] x, input logic [63:0] y);
    return op == ALU_SUB ? x - y :
           op == ALU_AND ? x & y :
           op == ALU_OR  ? x | y :
           op == ALU_SLT ? {63'd0, $signed(x) < $signed(y)} : x + y;
  endfunction
endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32 x XLEN registers, two async read ports, one sync write port, $0 reads zero
module mips_mc_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [32];
  // Cleared asynchronously on reset; writes aimed at $0 are dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core, one shared ALU, unified req/ready memory port.
// Define MIPS_JUMP_EN to make j (op 0x02) legal; otherwise it halts like any illegal opcode.
module mips_multicycle_core import mips_mc_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     inst_out,
  output logic            retire,
  output logic            halted
);
`ifdef MIPS_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif
  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, alu_out, mdr, rd1, rd2, imm_ext, alu_res;
  logic [5:0]      op, funct;
  logic            legal, is_mem;
  logic [63:0]     pc_ext;
  logic [PC_W-1:0] jump_pc;
  alu_op_t         alu_op;
  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign imm_ext = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign is_mem  = op == OP_LW || op == OP_SW;
  assign legal   = (op == OP_RTYPE && funct_ok(funct)) || is_mem || op == OP_BEQ ||
                   op == OP_ADDI || (JUMP_EN && op == OP_J);
  assign alu_op  = op == OP_RTYPE ? funct_alu(funct) : ALU_ADD;
  assign alu_res = XLEN'(alu(alu_op, 64'($signed(a)), 64'($signed(op == OP_RTYPE ? b : imm_ext))));
  assign pc_ext  = 64'(pc);
  assign jump_pc = PC_W'({pc_ext[63:26], ir[25:0]});
  assign mem_req   = reset && (state == S_FETCH || state == S_MEM);
  assign mem_we    = state == S_MEM && op == OP_SW;
  assign mem_addr  = state == S_MEM ? alu_out[PC_W-1:0] : pc;
  assign mem_wdata = b;
  assign pc_out    = pc;
  assign inst_out  = ir;
  mips_mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .we    (state == S_WB),
    .wa    (op == OP_RTYPE ? ir[15:11] : ir[20:16]),
    .wd    (op == OP_LW ? mdr : alu_out),
    .rd1   (rd1),
    .rd2   (rd2)
  );
  // Instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], sticky HALT on illegal ops
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retire  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH:
          if (mem_ready) begin
            ir    <= 32'(mem_rdata);
            pc    <= pc + 1'b1;
            state <= S_DECODE;
          end
        S_DECODE: begin
          a       <= rd1;
          b       <= rd2;
          alu_out <= XLEN'(pc) + imm_ext;
          halted  <= !legal;
          state   <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC:
          if (op == OP_BEQ || op == OP_J) begin
            pc     <= op == OP_J ? jump_pc : (a == b ? alu_out[PC_W-1:0] : pc);
            retire <= 1'b1;
            state  <= S_FETCH;
          end else begin
            alu_out <= alu_res;
            state   <= is_mem ? S_MEM : S_WB;
          end
        S_MEM:
          if (mem_ready) begin
            mdr    <= mem_rdata;
            retire <= op == OP_SW;
            state  <= op == OP_SW ? S_FETCH : S_WB;
          end
        S_WB: begin
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
endmodule
